// File: rtl/lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl
// Load/store access controller between the EX/MEM stage and the data-memory
// bus (req/gnt/rvalid). It builds byte enables, replicates store data across
// lanes, extracts and sign/zero-extends load data, holds the pipeline with
// ldst_stall until the access completes, and reports misaligned accesses and
// bus errors/timeouts as one-cycle exception pulses.
//
// Ports
//   clk, rst_n        core clock, asynchronous active-low reset
//   ex_*              access request from EX/MEM, held stable while ldst_stall=1
//   data_req_o ..     bus request channel (addr/we/be/wdata valid with req)
//   data_gnt_i        bus accepted the request
//   data_rvalid_i     response valid, with data_rdata_i / data_err_i
//   ldst_stall        pipeline freeze, released combinationally on completion
//   lsu_rvalid/rdata  extended load result, one-cycle pulse
//   misaligned_exc    one-cycle pulse: misaligned address or illegal size
//   bus_err_exc       one-cycle pulse: bus error response or timeout
//   exc_addr          faulting byte address, valid with either pulse
//   fsm_state         current controller state (0=IDLE,1=WAIT_GNT,2=WAIT_RSP)
//
// Bus handshake: the request is transferred in the cycle where data_req_o and
// data_gnt_i are both 1; address/we/be/wdata stay stable from the first req
// cycle until that transfer. The response is taken in the first cycle
// data_rvalid_i=1 while waiting for it; data_err_i only means anything when
// data_rvalid_i=1. Responses or grants seen in IDLE are ignored.
// -----------------------------------------------------------------------------
module lsu_mem_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_we,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        data_req_o,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  output logic        ldst_stall,
  output logic [31:0] lsu_rdata,
  output logic        lsu_rvalid,
  output logic        misaligned_exc,
  output logic        bus_err_exc,
  output logic [31:0] exc_addr,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;

  logic        illegal;
  logic        accept;
  logic        timeout_hit;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] rdata_ext;

  always_comb begin
    illegal = (ex_size == 2'b11) ||
              ((ex_size == 2'b01) && ex_addr[0]) ||
              ((ex_size == 2'b10) && (ex_addr[1:0] != 2'b00));
    accept  = (state == IDLE) && ex_valid && !illegal;
    // Counter is only meaningful while an access is outstanding.
    timeout_hit = (state != IDLE) && (cnt == 8'(TIMEOUT - 1));
    // Stall drops in the completing or aborting cycle so the pipeline
    // advances in step with the FSM returning to IDLE.
    ldst_stall = accept ||
                 ((state == WAIT_GNT) && !timeout_hit) ||
                 ((state == WAIT_RSP) && !data_rvalid_i && !timeout_hit);
    data_req_o  = (state == WAIT_GNT);
    data_addr_o = {addr_q[31:2], 2'b00};
    fsm_state   = state;
  end

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = ex_wdata;
    case (ex_size)
      2'b00: begin
        be_next    = 4'b0001 << ex_addr[1:0];
        wdata_next = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        be_next    = 4'b0011 << ex_addr[1:0];
        wdata_next = {2{ex_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_sel = data_rdata_i[7:0];
      2'd1:    byte_sel = data_rdata_i[15:8];
      2'd2:    byte_sel = data_rdata_i[23:16];
      default: byte_sel = data_rdata_i[31:24];
    endcase
    half_sel = addr_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    case (size_q)
      2'b00:   rdata_ext = uns_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   rdata_ext = uns_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: rdata_ext = data_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= 8'd0;
      uns_q          <= 1'b0;
      size_q         <= 2'b00;
      addr_q         <= 32'd0;
      data_we_o      <= 1'b0;
      data_be_o      <= 4'b0000;
      data_wdata_o   <= 32'd0;
      lsu_rdata      <= 32'd0;
      lsu_rvalid     <= 1'b0;
      misaligned_exc <= 1'b0;
      bus_err_exc    <= 1'b0;
      exc_addr       <= 32'd0;
    end else begin
      lsu_rvalid     <= 1'b0;
      misaligned_exc <= 1'b0;
      bus_err_exc    <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            if (illegal) begin
              misaligned_exc <= 1'b1;
              exc_addr       <= ex_addr;
            end else begin
              uns_q        <= ex_unsigned;
              size_q       <= ex_size;
              addr_q       <= ex_addr;
              data_we_o    <= ex_we;
              data_be_o    <= be_next;
              data_wdata_o <= wdata_next;
              cnt          <= 8'd0;
              state        <= WAIT_GNT;
            end
          end
        end
        WAIT_GNT: begin
          cnt <= cnt + 8'd1;
          // A grant in the timeout cycle does not count as completion.
          if (timeout_hit) begin
            state       <= IDLE;
            bus_err_exc <= 1'b1;
            exc_addr    <= addr_q;
          end else if (data_gnt_i) begin
            state <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          cnt <= cnt + 8'd1;
          // A response in the timeout cycle still completes the access.
          if (data_rvalid_i) begin
            state <= IDLE;
            if (data_err_i) begin
              bus_err_exc <= 1'b1;
              exc_addr    <= addr_q;
            end else if (!data_we_o) begin
              lsu_rvalid <= 1'b1;
              lsu_rdata  <= rdata_ext;
            end
          end else if (timeout_hit) begin
            state       <= IDLE;
            bus_err_exc <= 1'b1;
            exc_addr    <= addr_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ex_valid = 0, ex_we = 0, ex_unsigned = 0;
  logic [1:0]  ex_size = 0;
  logic [31:0] ex_addr = 0, ex_wdata = 0;
  logic        data_req_o, data_we_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic [3:0]  data_be_o;
  logic        data_gnt_i = 0, data_rvalid_i = 0, data_err_i = 0;
  logic [31:0] data_rdata_i = 0;
  logic        ldst_stall, lsu_rvalid, misaligned_exc, bus_err_exc;
  logic [31:0] lsu_rdata, exc_addr;
  logic [1:0]  fsm_state;

  lsu_mem_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_we(ex_we), .ex_size(ex_size),
    .ex_unsigned(ex_unsigned), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .data_req_o(data_req_o), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_rdata_i(data_rdata_i), .data_err_i(data_err_i),
    .ldst_stall(ldst_stall), .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
    .misaligned_exc(misaligned_exc), .bus_err_exc(bus_err_exc),
    .exc_addr(exc_addr), .fsm_state(fsm_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    ex_valid = 1; ex_we = we; ex_size = size; ex_unsigned = uns;
    ex_addr = addr; ex_wdata = wdata;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exp_mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[12];

  // Zero-wait bus access, or a misaligned rejection, checked cycle by cycle.
  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    step();
    set_ex(v.we, v.size, v.uns, v.addr, v.wdata);
    @(negedge clk);
    chk({tag, "_accept_stall"}, {31'd0, ldst_stall}, {31'd0, !v.exp_mis});
    chk({tag, "_accept_req"}, {31'd0, data_req_o}, 32'd0);
    if (v.exp_mis) begin
      step();
      ex_valid = 0;
      @(negedge clk);
      chk({tag, "_mis_pulse"}, {31'd0, misaligned_exc}, 32'd1);
      chk({tag, "_mis_addr"}, exc_addr, v.addr);
      chk({tag, "_mis_noreq"}, {31'd0, data_req_o}, 32'd0);
      step();
      @(negedge clk);
      chk({tag, "_mis_pulse_end"}, {31'd0, misaligned_exc}, 32'd0);
    end else begin
      step();
      data_gnt_i = 1;
      @(negedge clk);
      chk({tag, "_req"}, {31'd0, data_req_o}, 32'd1);
      chk({tag, "_addr"}, data_addr_o, v.addr & 32'hFFFF_FFFC);
      chk({tag, "_be"}, {28'd0, data_be_o}, {28'd0, v.exp_be});
      chk({tag, "_we"}, {31'd0, data_we_o}, {31'd0, v.we});
      chk({tag, "_wdata"}, data_wdata_o, v.exp_wdata);
      chk({tag, "_gnt_stall"}, {31'd0, ldst_stall}, 32'd1);
      step();
      data_gnt_i = 0; data_rvalid_i = 1; data_rdata_i = v.rdata;
      @(negedge clk);
      chk({tag, "_rsp_release"}, {31'd0, ldst_stall}, 32'd0);
      chk({tag, "_rsp_noreq"}, {31'd0, data_req_o}, 32'd0);
      step();
      data_rvalid_i = 0; ex_valid = 0;
      @(negedge clk);
      chk({tag, "_rvalid"}, {31'd0, lsu_rvalid}, {31'd0, !v.we});
      if (!v.we) begin
        exp_q.push_back(v.exp_rdata);
        chk({tag, "_rdata"}, lsu_rdata, exp_q.pop_front());
      end
      chk({tag, "_no_buserr"}, {31'd0, bus_err_exc}, 32'd0);
    end
  endtask

  int stall_cnt;

  initial begin
    //                we  size  uns addr          wdata          rdata          mis be       exp_wdata      exp_rdata
    vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h103, 32'h1234_5678, 32'h8000_0000, 1'b0, 4'b1000, 32'h7878_7878, 32'hFFFF_FF80};
    vecs[1]  = '{1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_BEEF, 32'h0,         1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vecs[2]  = '{1'b0, 2'b10, 1'b0, 32'h101, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[3]  = '{1'b0, 2'b00, 1'b1, 32'h101, 32'h0,         32'h0000_A500, 1'b0, 4'b0010, 32'h0,         32'h0000_00A5};
    vecs[4]  = '{1'b0, 2'b01, 1'b0, 32'h200, 32'h0,         32'h1234_8001, 1'b0, 4'b0011, 32'h0,         32'hFFFF_8001};
    vecs[5]  = '{1'b0, 2'b01, 1'b1, 32'h206, 32'h0,         32'hF00D_1234, 1'b0, 4'b1100, 32'h0,         32'h0000_F00D};
    vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h300, 32'h0,         32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0,         32'hDEAD_BEEF};
    vecs[7]  = '{1'b1, 2'b00, 1'b0, 32'h400, 32'h0000_00AB, 32'h0,         1'b0, 4'b0001, 32'hABAB_ABAB, 32'h0};
    vecs[8]  = '{1'b1, 2'b10, 1'b0, 32'h404, 32'hCAFE_F00D, 32'h0,         1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[9]  = '{1'b0, 2'b01, 1'b0, 32'h103, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[10] = '{1'b0, 2'b11, 1'b0, 32'h100, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[11] = '{1'b0, 2'b00, 1'b0, 32'h102, 32'h0,         32'h007F_0000, 1'b0, 4'b0100, 32'h0,         32'h0000_007F};
    // Extra store lanes: half at upper lane repeats low halfword.
    // ---------------- reset state ----------------
    #12;
    chk("rst_req", {31'd0, data_req_o}, 32'd0);
    chk("rst_stall", {31'd0, ldst_stall}, 32'd0);
    chk("rst_rdata", lsu_rdata, 32'd0);
    chk("rst_exc_addr", exc_addr, 32'd0);
    chk("rst_rvalid", {31'd0, lsu_rvalid}, 32'd0);
    chk("rst_state", {30'd0, fsm_state}, 32'd0);
    step();
    rst_n = 1;

    // ---------------- table vectors ----------------
    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // ---------------- delayed grant and response ----------------
    // cycle 0 accept, 1..3 no gnt, 4 gnt, 5 no rvalid, 6 rvalid.
    stall_cnt = 0;
    for (int c = 0; c < 7; c++) begin
      step();
      if (c == 0) set_ex(1'b0, 2'b10, 1'b0, 32'h500, 32'h0);
      data_gnt_i = (c == 4);
      data_rvalid_i = (c == 6);
      data_rdata_i = 32'h1122_3344;
      @(negedge clk);
      if (ldst_stall) stall_cnt++;
      chk($sformatf("dly_req_c%0d", c), {31'd0, data_req_o}, {31'd0, (c >= 1 && c <= 4)});
      if (c >= 1 && c <= 4) chk($sformatf("dly_addr_c%0d", c), data_addr_o, 32'h500);
    end
    chk("dly_release", {31'd0, ldst_stall}, 32'd0);
    chk("dly_stall_cycles", stall_cnt, 32'd6);
    step();
    data_rvalid_i = 0; ex_valid = 0;
    @(negedge clk);
    chk("dly_rvalid", {31'd0, lsu_rvalid}, 32'd1);
    chk("dly_rdata", lsu_rdata, 32'h1122_3344);

    // ---------------- timeout, grant never arrives ----------------
    stall_cnt = 0;
    for (int c = 0; c < 9; c++) begin
      step();
      if (c == 0) set_ex(1'b0, 2'b00, 1'b0, 32'h600, 32'h0);
      @(negedge clk);
      if (ldst_stall) stall_cnt++;
      chk($sformatf("to_buserr_c%0d", c), {31'd0, bus_err_exc}, 32'd0);
    end
    chk("to_stall_cycles", stall_cnt, 32'd8);
    chk("to_release", {31'd0, ldst_stall}, 32'd0);
    step();
    ex_valid = 0; data_rvalid_i = 1; data_rdata_i = 32'h0000_0055;  // late response
    @(negedge clk);
    chk("to_pulse", {31'd0, bus_err_exc}, 32'd1);
    chk("to_exc_addr", exc_addr, 32'h600);
    chk("to_state_idle", {30'd0, fsm_state}, 32'd0);
    step();
    data_rvalid_i = 0;
    @(negedge clk);
    chk("to_late_rsp_ignored", {31'd0, lsu_rvalid}, 32'd0);
    chk("to_pulse_end", {31'd0, bus_err_exc}, 32'd0);
    chk("to_late_noreq", {31'd0, data_req_o}, 32'd0);

    // ---------------- error response on LHU ----------------
    step();
    set_ex(1'b0, 2'b01, 1'b1, 32'h210, 32'h0);
    step();
    data_gnt_i = 1;
    step();
    data_gnt_i = 0; data_rvalid_i = 1; data_err_i = 1; data_rdata_i = 32'h0000_1234;
    @(negedge clk);
    chk("err_release", {31'd0, ldst_stall}, 32'd0);
    step();
    data_rvalid_i = 0; data_err_i = 0; ex_valid = 0;
    @(negedge clk);
    chk("err_pulse", {31'd0, bus_err_exc}, 32'd1);
    chk("err_no_rvalid", {31'd0, lsu_rvalid}, 32'd0);
    chk("err_exc_addr", exc_addr, 32'h210);

    // ---------------- back-to-back loads ----------------
    step();
    set_ex(1'b0, 2'b00, 1'b1, 32'h800, 32'h0);
    step();
    data_gnt_i = 1;
    step();
    data_gnt_i = 0; data_rvalid_i = 1; data_rdata_i = 32'h0000_00FF;
    step();
    data_rvalid_i = 0;
    set_ex(1'b0, 2'b00, 1'b0, 32'h801, 32'h0);
    @(negedge clk);
    chk("b2b_first_rvalid", {31'd0, lsu_rvalid}, 32'd1);
    chk("b2b_first_rdata", lsu_rdata, 32'h0000_00FF);
    chk("b2b_second_stall", {31'd0, ldst_stall}, 32'd1);
    step();
    data_gnt_i = 1;
    @(negedge clk);
    chk("b2b_second_req", {31'd0, data_req_o}, 32'd1);
    chk("b2b_second_be", {28'd0, data_be_o}, 32'h2);
    step();
    data_gnt_i = 0; data_rvalid_i = 1; data_rdata_i = 32'h0000_8000;
    step();
    data_rvalid_i = 0; ex_valid = 0;
    @(negedge clk);
    chk("b2b_second_rvalid", {31'd0, lsu_rvalid}, 32'd1);
    chk("b2b_second_rdata", lsu_rdata, 32'hFFFF_FF80);

    // ---------------- async reset in WAIT_GNT ----------------
    step();
    set_ex(1'b1, 2'b10, 1'b0, 32'h700, 32'h5555_AAAA);
    step();
    @(negedge clk);
    chk("rstmid_req_before", {31'd0, data_req_o}, 32'd1);
    #2;
    rst_n = 0; ex_valid = 0;
    #1;
    chk("rstmid_req_drop", {31'd0, data_req_o}, 32'd0);
    chk("rstmid_stall_drop", {31'd0, ldst_stall}, 32'd0);
    chk("rstmid_state", {30'd0, fsm_state}, 32'd0);
    step();
    rst_n = 1;
    @(negedge clk);
    chk("rstmid_no_buserr", {31'd0, bus_err_exc}, 32'd0);
    chk("rstmid_no_mis", {31'd0, misaligned_exc}, 32'd0);
    chk("rstmid_no_rvalid", {31'd0, lsu_rvalid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
